// File: rtl/fp_int_converter.sv
// Multi-cycle int<->float converter: one-bit-per-cycle normaliser (int->float) or denormaliser (float->int).
// Optional macro FP_CVT_ROUND_EN: int->float rounds to nearest-even instead of truncating.
module fp_int_converter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] din,
    output logic        busy,
    output logic        done,
    output logic [31:0] dout,
    output logic        overflow
);

    localparam logic [7:0] EXP_TOP = 8'd158;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_ROUND,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_op;
    logic        r_sign;
    logic        r_special;
    logic        r_res_ovf;
    logic [31:0] r_mag;
    logic [31:0] r_res;
    logic [7:0]  r_exp;
    logic [4:0]  r_cnt;

    logic        r_done;
    logic        r_ovf;
    logic [31:0] r_dout;

    logic [31:0] w_int_mag;
    logic [7:0]  w_f_exp;
    logic        w_special;
    logic [31:0] w_spec_res;
    logic        w_spec_ovf;
    logic        w_shift_done;
    logic [22:0] w_mant;
    logic [7:0]  w_exp_r;
    logic [31:0] w_i2f;
    logic [31:0] w_f2i;
`ifdef FP_CVT_ROUND_EN
    logic        w_guard;
    logic        w_sticky;
    logic        w_inc;
    logic [23:0] w_mant_sum;
`endif

    // Zero and out-of-range operands resolve at load time and skip the shifter (N=0).
    always_comb begin
        w_int_mag  = din[31] ? (~din + 32'd1) : din;
        w_f_exp    = din[30:23];
        w_special  = 1'b0;
        w_spec_res = '0;
        w_spec_ovf = 1'b0;
        if (!op) begin
            w_special = (din == 32'd0);
        end else if (w_f_exp < 8'd127) begin
            w_special = 1'b1;
        end else if (din == 32'hCF00_0000) begin
            w_special  = 1'b1;
            w_spec_res = 32'h8000_0000;
        end else if (w_f_exp >= EXP_TOP) begin
            w_special  = 1'b1;
            w_spec_ovf = 1'b1;
            w_spec_res = din[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

    assign w_shift_done = r_special | (r_op ? (r_cnt == 5'd0) : r_mag[31]);

    always_comb begin
        w_mant  = r_mag[30:8];
        w_exp_r = r_exp;
`ifdef FP_CVT_ROUND_EN
        w_guard    = r_mag[7];
        w_sticky   = |r_mag[6:0];
        w_inc      = w_guard & (w_sticky | r_mag[8]);
        w_mant_sum = {1'b0, r_mag[30:8]} + {23'd0, w_inc};
        w_mant     = w_mant_sum[22:0];
        w_exp_r    = r_exp + {7'd0, w_mant_sum[23]};
`endif
        w_i2f = {r_sign, w_exp_r, w_mant};
        w_f2i = r_sign ? (~r_mag + 32'd1) : r_mag;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_SHIFT;
            S_SHIFT: if (w_shift_done) w_next_state = S_ROUND;
            S_ROUND: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: working registers carry no reset; the state register alone gates their use.
    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    r_op      <= op;
                    r_sign    <= din[31];
                    r_special <= w_special;
                    r_res     <= w_spec_res;
                    r_res_ovf <= w_spec_ovf;
                    if (op) begin
                        r_mag <= {1'b1, din[22:0], 8'd0};
                        r_cnt <= 5'(EXP_TOP - w_f_exp);
                    end else begin
                        r_mag <= w_int_mag;
                        r_exp <= EXP_TOP;
                        r_cnt <= 5'd0;
                    end
                end
            end
            S_SHIFT: begin
                if (!w_shift_done) begin
                    if (r_op) begin
                        r_mag <= r_mag >> 1;
                        r_cnt <= r_cnt - 5'd1;
                    end else begin
                        r_mag <= r_mag << 1;
                        r_exp <= r_exp - 8'd1;
                    end
                end
            end
            S_ROUND: begin
                if (!r_special) r_res <= r_op ? w_f2i : w_i2f;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
            r_dout <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_DONE) begin
                r_done <= 1'b1;
                r_dout <= r_res;
                r_ovf  <= r_res_ovf;
            end
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign dout     = r_dout;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_fp_int_converter.sv
// Self-checking bench for fp_int_converter: scoreboard of expected results and latencies,
// one task per feature; checks values, done timing, saturation, ignored starts and reset.
module tb_fp_int_converter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] din;
    logic        busy;
    logic        done;
    logic [31:0] dout;
    logic        overflow;

    typedef struct {
        logic [31:0] dout;
        logic        ovf;
        int          n;
    } exp_t;

    typedef struct {
        logic        op;
        logic [31:0] din;
        logic [31:0] dout;
        logic        ovf;
        int          n;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

`ifdef FP_CVT_ROUND_EN
    localparam logic [31:0] MAXINT_F  = 32'h4F00_0000;
    localparam logic [31:0] ODD_TIE_F = 32'h4B80_0002;
`else
    localparam logic [31:0] MAXINT_F  = 32'h4EFF_FFFF;
    localparam logic [31:0] ODD_TIE_F = 32'h4B80_0001;
`endif

    fp_int_converter dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .din      (din),
        .busy     (busy),
        .done     (done),
        .dout     (dout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one start pulse sampled by the next edge and records the expected result.
    task automatic issue(input logic i_op, input logic [31:0] i_din,
                         input logic [31:0] e_dout, input logic e_ovf, input int e_n);
        exp_t e;
        e.dout = e_dout;
        e.ovf  = e_ovf;
        e.n    = e_n;
        sb.push_back(e);
        @(negedge clk);
        op    = i_op;
        din   = i_din;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the start-sampling edge until done is seen (bounded).
    task automatic wait_done(output logic [31:0] o_dout, output logic o_ovf,
                             output int lat, output bit timed_out);
        lat       = 0;
        timed_out = 1'b0;
        o_dout    = '0;
        o_ovf     = 1'b0;
        while (1) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) begin
                o_dout = dout;
                o_ovf  = overflow;
                break;
            end
            if (lat >= 200) begin
                timed_out = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        din   = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (done !== 1'b0)     begin n_err++; $display("FAIL reset_done got=%b want=0", done); end
        n_cmp++; if (dout !== 32'd0)    begin n_err++; $display("FAIL reset_dout got=%h want=00000000", dout); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b want=0", overflow); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_int_to_float();
        vec_t tbl [0:7] = '{
            '{1'b0, 32'h0000_0001, 32'h3F80_0000, 1'b0, 31},
            '{1'b0, 32'hFFFF_FFFB, 32'hC0A0_0000, 1'b0, 29},
            '{1'b0, 32'h8000_0000, 32'hCF00_0000, 1'b0, 0},
            '{1'b0, 32'h7FFF_FFFF, MAXINT_F,      1'b0, 1},
            '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 0},
            '{1'b0, 32'h0000_0064, 32'h42C8_0000, 1'b0, 25},
            '{1'b0, 32'h0100_0001, 32'h4B80_0000, 1'b0, 7},
            '{1'b0, 32'h0100_0003, ODD_TIE_F,     1'b0, 7}
        };
        exp_t        e;
        logic [31:0] g_dout;
        logic        g_ovf;
        int          lat;
        bit          to;
        foreach (tbl[i]) begin
            issue(tbl[i].op, tbl[i].din, tbl[i].dout, tbl[i].ovf, tbl[i].n);
            wait_done(g_dout, g_ovf, lat, to);
            e = sb.pop_front();
            n_cmp++;
            if (to) begin
                n_err++; $display("FAIL i2f_timeout din=%h no done within 200 cycles", tbl[i].din);
            end else begin
                if (g_dout !== e.dout) begin n_err++; $display("FAIL i2f_dout din=%h got=%h want=%h", tbl[i].din, g_dout, e.dout); end
                n_cmp++; if (g_ovf !== e.ovf) begin n_err++; $display("FAIL i2f_ovf din=%h got=%b want=%b", tbl[i].din, g_ovf, e.ovf); end
                n_cmp++; if (lat != e.n + 3) begin n_err++; $display("FAIL i2f_latency din=%h got=%0d want=%0d", tbl[i].din, lat, e.n + 3); end
            end
        end
    endtask

    task automatic test_float_to_int();
        vec_t tbl [0:6] = '{
            '{1'b1, 32'h4049_0FDB, 32'h0000_0003, 1'b0, 30},
            '{1'b1, 32'hC0F0_0000, 32'hFFFF_FFF9, 1'b0, 29},
            '{1'b1, 32'h3F00_0000, 32'h0000_0000, 1'b0, 0},
            '{1'b1, 32'h3F80_0000, 32'h0000_0001, 1'b0, 31},
            '{1'b1, 32'hC2F6_0000, 32'hFFFF_FF85, 1'b0, 25},
            '{1'b1, 32'h0000_0001, 32'h0000_0000, 1'b0, 0},
            '{1'b1, 32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1}
        };
        exp_t        e;
        logic [31:0] g_dout;
        logic        g_ovf;
        int          lat;
        bit          to;
        foreach (tbl[i]) begin
            issue(tbl[i].op, tbl[i].din, tbl[i].dout, tbl[i].ovf, tbl[i].n);
            wait_done(g_dout, g_ovf, lat, to);
            e = sb.pop_front();
            n_cmp++;
            if (to) begin
                n_err++; $display("FAIL f2i_timeout din=%h no done within 200 cycles", tbl[i].din);
            end else begin
                if (g_dout !== e.dout) begin n_err++; $display("FAIL f2i_dout din=%h got=%h want=%h", tbl[i].din, g_dout, e.dout); end
                n_cmp++; if (g_ovf !== e.ovf) begin n_err++; $display("FAIL f2i_ovf din=%h got=%b want=%b", tbl[i].din, g_ovf, e.ovf); end
                n_cmp++; if (lat != e.n + 3) begin n_err++; $display("FAIL f2i_latency din=%h got=%0d want=%0d", tbl[i].din, lat, e.n + 3); end
            end
        end
    endtask

    task automatic test_saturation();
        vec_t tbl [0:4] = '{
            '{1'b1, 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 0},
            '{1'b1, 32'hFF80_0000, 32'h8000_0000, 1'b1, 0},
            '{1'b1, 32'hCF00_0000, 32'h8000_0000, 1'b0, 0},
            '{1'b1, 32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 0},
            '{1'b1, 32'hCF00_0001, 32'h8000_0000, 1'b1, 0}
        };
        exp_t        e;
        logic [31:0] g_dout;
        logic        g_ovf;
        int          lat;
        bit          to;
        foreach (tbl[i]) begin
            issue(tbl[i].op, tbl[i].din, tbl[i].dout, tbl[i].ovf, tbl[i].n);
            wait_done(g_dout, g_ovf, lat, to);
            e = sb.pop_front();
            n_cmp++;
            if (to) begin
                n_err++; $display("FAIL sat_timeout din=%h no done within 200 cycles", tbl[i].din);
            end else begin
                if (g_dout !== e.dout) begin n_err++; $display("FAIL sat_dout din=%h got=%h want=%h", tbl[i].din, g_dout, e.dout); end
                n_cmp++; if (g_ovf !== e.ovf) begin n_err++; $display("FAIL sat_ovf din=%h got=%b want=%b", tbl[i].din, g_ovf, e.ovf); end
                n_cmp++; if (lat != e.n + 3) begin n_err++; $display("FAIL sat_latency din=%h got=%0d want=%0d", tbl[i].din, lat, e.n + 3); end
            end
        end
    endtask

    task automatic test_pulse_and_hold();
        exp_t        e;
        logic [31:0] g_dout;
        logic        g_ovf;
        int          lat;
        bit          to;
        issue(1'b0, 32'h0000_0002, 32'h4000_0000, 1'b0, 30);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_after_accept got=%b want=1", busy); end
        wait_done(g_dout, g_ovf, lat, to);
        e = sb.pop_front();
        n_cmp++;
        if (to) begin
            n_err++; $display("FAIL hold_timeout no done within 200 cycles");
        end else if (g_dout !== e.dout || lat != e.n + 3) begin
            n_err++; $display("FAIL hold_result got=%h/%0d want=%h/%0d", g_dout, lat, e.dout, e.n + 3);
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_at_done got=%b want=0", busy); end
        @(posedge clk);
        #1;
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL done_pulse_width got=%b want=0", done); end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (dout !== e.dout) begin n_err++; $display("FAIL dout_hold got=%h want=%h", dout, e.dout); end
        n_cmp++; if (overflow !== e.ovf) begin n_err++; $display("FAIL ovf_hold got=%b want=%b", overflow, e.ovf); end
    endtask

    // Extra starts land mid-SHIFT and in DONE; both must be dropped.
    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        int   extra_done;
        int   extra_busy;
        issue(1'b1, 32'h4049_0FDB, 32'h0000_0003, 1'b0, 30);
        lat = 0;
        while (1) begin
            @(posedge clk);
            #1;
            lat++;
            if (done || lat >= 200) break;
            start = (lat == 3) || (lat == 32);
            op    = 1'b0;
            din   = 32'h0000_0001;
        end
        start = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (!done) begin
            n_err++; $display("FAIL b2b_timeout no done within 200 cycles");
        end else if (dout !== e.dout) begin
            n_err++; $display("FAIL b2b_dout got=%h want=%h", dout, e.dout);
        end
        n_cmp++; if (lat != e.n + 3) begin n_err++; $display("FAIL b2b_latency got=%0d want=%0d", lat, e.n + 3); end
        extra_done = 0;
        extra_busy = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
        n_cmp++; if (extra_done != 0) begin n_err++; $display("FAIL b2b_extra_done got=%0d want=0", extra_done); end
        n_cmp++; if (extra_busy != 0) begin n_err++; $display("FAIL b2b_extra_busy got=%0d want=0", extra_busy); end
    endtask

    // Reset in cycle 10 of a 34-cycle conversion, with a start in the same cycle.
    task automatic test_reset_mid();
        int lat;
        int seen_done;
        int seen_busy;
        @(negedge clk);
        op    = 1'b0;
        din   = 32'h0000_0001;
        start = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        seen_done = 0;
        for (lat = 1; lat <= 10; lat++) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
            if (lat == 9) begin
                rst   = 1'b1;
                start = 1'b1;
                din   = 32'h0000_0007;
            end
        end
        rst   = 1'b0;
        start = 1'b0;
        n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        n_cmp++; if (dout !== 32'd0)    begin n_err++; $display("FAIL rstmid_dout got=%h want=00000000", dout); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rstmid_ovf got=%b want=0", overflow); end
        seen_busy = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
            if (busy) seen_busy++;
        end
        n_cmp++; if (seen_done != 0) begin n_err++; $display("FAIL rstmid_done_count got=%0d want=0", seen_done); end
        n_cmp++; if (seen_busy != 0) begin n_err++; $display("FAIL rstmid_start_with_rst got_busy_cycles=%0d want=0", seen_busy); end
    endtask

    initial begin
        test_reset();
        test_int_to_float();
        test_float_to_int();
        test_saturation();
        test_pulse_and_hold();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
